// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out shift transmitter.
// Accepts a (width+1)-bit word through a valid/ready load handshake and
// shifts it out MSB first, one bit per clock, with a qualifying valid strobe
// and a last-bit marker. A new word can be accepted during the last bit of
// the current frame, so consecutive frames run with no gap.
module piso_shift_tx #(
    parameter int width = 7
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [width:0]   parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_last
);

    // Counter wide enough to hold the MSB index.
    localparam int CW = $clog2(width + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(width);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t          r_state;
    logic [width:0]  r_sreg;
    logic [CW-1:0]   r_cnt;
    logic            r_serial_valid;
    logic            r_frame_last;

    logic            w_last_bit;
    logic            w_accept;
    logic [width:0]  w_sreg_shifted;

    // The last bit of a frame is on the line when shifting with cnt at zero.
    assign w_last_bit     = (r_state == ST_SHIFT) && (r_cnt == '0);
    // Ready in IDLE or on the last bit, which is what allows back-to-back frames.
    assign load_ready     = (r_state == ST_IDLE) || w_last_bit;
    assign w_accept       = load_valid && load_ready;
    assign w_sreg_shifted = {r_sreg[width-1:0], 1'b0};

    // Outputs come straight from flops; the AND keeps the line at 0 between frames.
    assign serial_out     = r_sreg[width] & r_serial_valid;
    assign serial_valid   = r_serial_valid;
    assign frame_last     = r_frame_last;

    // Control FSM, shift register, bit counter and registered output strobes.
    // NOTE: every register here is assigned with <= so all of them see the
    // pre-edge values of each other; blocking = would make the shift and the
    // counter decision depend on statement order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state        <= ST_IDLE;
            r_sreg         <= '0;
            r_cnt          <= '0;
            r_serial_valid <= 1'b0;
            r_frame_last   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state        <= ST_SHIFT;
                        r_sreg         <= parallel_in;
                        r_cnt          <= CNT_MAX;
                        r_serial_valid <= 1'b1;
                        // width >= 1, so a fresh frame never starts on its last bit.
                        r_frame_last   <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        // Mid-frame: move the next bit up and count down.
                        r_sreg         <= w_sreg_shifted;
                        r_cnt          <= r_cnt - CNT_ONE;
                        r_serial_valid <= 1'b1;
                        r_frame_last   <= (r_cnt == CNT_ONE);
                    end else if (w_accept) begin
                        // Last bit and a new word offered: reload without a gap.
                        r_sreg         <= parallel_in;
                        r_cnt          <= CNT_MAX;
                        r_serial_valid <= 1'b1;
                        r_frame_last   <= 1'b0;
                    end else begin
                        // Last bit and nothing waiting: drop back to idle, clear
                        // the shifter so no residue can reach the line later.
                        r_state        <= ST_IDLE;
                        r_sreg         <= '0;
                        r_cnt          <= '0;
                        r_serial_valid <= 1'b0;
                        r_frame_last   <= 1'b0;
                    end
                end

                default: begin
                    r_state        <= ST_IDLE;
                    r_sreg         <= '0;
                    r_cnt          <= '0;
                    r_serial_valid <= 1'b0;
                    r_frame_last   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Testbench for piso_shift_tx: queue-based reference model checked every
// cycle, directed frames with literal bitstreams, a behavioural SIPO for
// loopback, a width=3 instance, and a randomized traffic phase.
module tb_piso_shift_tx;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic [W:0]   parallel_in = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         serial_out;
    logic         serial_valid;
    logic         frame_last;

    logic [3:0]   parallel_in3 = '0;
    logic         load_valid3 = 1'b0;
    logic         load_ready3;
    logic         serial_out3;
    logic         serial_valid3;
    logic         frame_last3;

    int n_checks = 0;
    int n_fail   = 0;

    // Bits still owed to the line; front entry is the bit on the line now.
    bit q[$];

    // Behavioural receiver: plain SIPO on the same edge.
    logic [W:0] sipo;

    piso_shift_tx #(.width(W)) u_dut (
        .clk          (clk),
        .clr          (clr),
        .parallel_in  (parallel_in),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_last   (frame_last)
    );

    piso_shift_tx #(.width(3)) u_dut3 (
        .clk          (clk),
        .clr          (clr),
        .parallel_in  (parallel_in3),
        .load_valid   (load_valid3),
        .load_ready   (load_ready3),
        .serial_out   (serial_out3),
        .serial_valid (serial_valid3),
        .frame_last   (frame_last3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge clr) begin
        if (!clr) sipo <= '0;
        else      sipo <= {sipo[W-1:0], serial_out};
    end

    // Reset empties the model immediately.
    always @(negedge clr) q.delete();

    // Model step at each edge, then compare all outputs just after it.
    always @(posedge clk) begin
        if (clr) begin
            bit acc;
            acc = load_valid && (q.size() <= 1);
            if (q.size() > 0) void'(q.pop_front());
            if (acc) for (int b = W; b >= 0; b--) q.push_back(parallel_in[b]);
        end
        #1;
        if (clr) begin
            check("model serial_valid", 64'(serial_valid), 64'(q.size() > 0));
            check("model serial_out",   64'(serial_out),   64'((q.size() > 0) ? q[0] : 1'b0));
            check("model frame_last",   64'(frame_last),   64'(q.size() == 1));
            check("model load_ready",   64'(load_ready),   64'(q.size() <= 1));
        end
    end

    logic [31:0] v_bits, v_val, v_last, v_rdy;

    // Offer a word, wait for the accept edge, land 2 units into the first bit.
    task automatic offer(input logic [W:0] word);
        @(negedge clk);
        parallel_in = word;
        load_valid  = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic sample_now();
        v_bits = {v_bits[30:0], serial_out};
        v_val  = {v_val[30:0],  serial_valid};
        v_last = {v_last[30:0], frame_last};
        v_rdy  = {v_rdy[30:0],  load_ready};
    endtask

    task automatic clear_vecs();
        v_bits = '0; v_val = '0; v_last = '0; v_rdy = '0;
    endtask

    initial begin
        // Reset state.
        #3;
        check("reset serial_out",   64'(serial_out),   64'd0);
        check("reset serial_valid", 64'(serial_valid), 64'd0);
        check("reset frame_last",   64'(frame_last),   64'd0);
        check("reset load_ready",   64'(load_ready),   64'd1);
        check("reset w3 ready",     64'(load_ready3),  64'd1);
        @(negedge clk); @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        // Single frame A5.
        clear_vecs();
        offer(8'hA5);
        load_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample_now();
            @(posedge clk); #2;
        end
        check("single bits",  64'(v_bits[9:0]), 64'({8'hA5, 2'b00}));
        check("single valid", 64'(v_val[9:0]),  64'(10'b1111111100));
        check("single last",  64'(v_last[9:0]), 64'(10'b0000000100));

        // Back-to-back A5 then 3C.
        clear_vecs();
        offer(8'hA5);
        parallel_in = 8'h3C;
        for (int i = 0; i < 18; i++) begin
            sample_now();
            if (i == 8) load_valid = 1'b0;
            @(posedge clk); #2;
        end
        check("b2b bits",  64'(v_bits[17:0]), 64'({8'hA5, 8'h3C, 2'b00}));
        check("b2b valid", 64'(v_val[17:0]),  64'(18'b111111111111111100));
        check("b2b last",  64'(v_last[17:0]), 64'(18'b000000010000000100));

        // Busy rejection: FF offered from cycle 2 of an A5 frame.
        clear_vecs();
        offer(8'hA5);
        load_valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            sample_now();
            if (i == 0) begin load_valid = 1'b1; parallel_in = 8'hFF; end
            if (i == 8) load_valid = 1'b0;
            @(posedge clk); #2;
        end
        check("busy ready", 64'(v_rdy[17:10]), 64'(8'b00000001));
        check("busy bits",  64'(v_bits[17:0]), 64'({8'hA5, 8'hFF, 2'b00}));

        // Reset mid-frame during the 4th bit, then 81.
        offer(8'hA5);
        load_valid = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        clr = 1'b0;
        #1;
        check("abort serial_out",   64'(serial_out),   64'd0);
        check("abort serial_valid", 64'(serial_valid), 64'd0);
        check("abort frame_last",   64'(frame_last),   64'd0);
        check("abort load_ready",   64'(load_ready),   64'd1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clear_vecs();
        offer(8'h81);
        load_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample_now();
            @(posedge clk); #2;
        end
        check("post-reset bits",  64'(v_bits[9:0]), 64'({8'h81, 2'b00}));
        check("post-reset valid", 64'(v_val[9:0]),  64'(10'b1111111100));

        // Loopback into the SIPO: C3 then 5A back-to-back.
        offer(8'hC3);
        parallel_in = 8'h5A;
        for (int i = 0; i < 18; i++) begin
            if (i == 8)  check("loopback C3", 64'(sipo), 64'(8'hC3));
            if (i == 16) check("loopback 5A", 64'(sipo), 64'(8'h5A));
            if (i == 8) load_valid = 1'b0;
            @(posedge clk); #2;
        end

        // width=3 instance: 1011.
        clear_vecs();
        @(negedge clk);
        parallel_in3 = 4'b1011;
        load_valid3  = 1'b1;
        @(posedge clk); #2;
        load_valid3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v_bits = {v_bits[30:0], serial_out3};
            v_val  = {v_val[30:0],  serial_valid3};
            v_last = {v_last[30:0], frame_last3};
            @(posedge clk); #2;
        end
        check("w3 bits",  64'(v_bits[5:0]), 64'(6'b101100));
        check("w3 valid", 64'(v_val[5:0]),  64'(6'b111100));
        check("w3 last",  64'(v_last[5:0]), 64'(6'b000100));

        // Randomized traffic; the per-cycle model compare does the checking.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            load_valid  = ($urandom_range(0, 3) != 0);
            parallel_in = 8'($urandom);
            if ($urandom_range(0, 150) == 0) begin
                #2 clr = 1'b0;
                @(negedge clk);
                clr = 1'b1;
            end
        end
        @(negedge clk);
        load_valid = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
